zap_wb_burst_arbiter: RTL and testbench
=======================================

// Module: zap_wb_burst_arbiter
// PURPOSE
//  Shares the single external Wishbone bus between the code-cache master (C) and the
//  data-cache master (D), ahead of the store-buffer adapter.
//  Burst-aware, registered-grant arbiter: data has priority, and code gets a bounded-starvation guarantee.
//  The grant is held for a whole burst (CTI 010 ... 111) or a whole classic cycle (CTI 000).
// PARAMETERS
//  STARVE_LIMIT  4  max consecutive D grants while C is requesting; the next grant goes to C. Range 1..15.
// PORTS
//  i_clk                       in   1   core clock, posedge
//  i_reset_n                   in   1   asynchronous, active-low reset
//  i_c_wb_cyc/stb/we           in   1   code master CYC/STB/WE
//  i_c_wb_sel                  in   4   code master byte selects
//  i_c_wb_dat                  in   32  code master write data
//  i_c_wb_adr                  in   32  code master address
//  i_c_wb_cti                  in   3   code master cycle type
//  o_c_wb_ack                  out  1   ack routed to the code master
//  i_d_wb_cyc/stb/we/sel/dat/adr/cti  in  1/1/1/4/32/32/3  data master, same meanings as C
//  o_d_wb_ack                  out  1   ack routed to the data master
//  o_wb_cyc/stb/we             out  1   merged bus CYC/STB/WE
//  o_wb_sel                    out  4   merged bus byte selects
//  o_wb_dat                    out  32  merged bus write data
//  o_wb_adr                    out  32  merged bus address
//  o_wb_cti                    out  3   merged bus cycle type
//  i_wb_ack                    in   1   bus ack
//  o_grant                     out  2   {D,C} one-hot current owner; 00 = idle
// BEHAVIOUR
//  - FSM states: IDLE, GNT_C, GNT_D. State, the starvation counter and o_grant are registered.
//  - Reset (async assert, sync deassert by the integrator): state=IDLE, counter=0, all outputs 0.
//    Asserting reset mid-burst aborts the burst at once; o_wb_cyc falls asynchronously.
//  - Request: req_x = i_x_wb_cyc & i_x_wb_stb.
//  - Arbitration in IDLE:
//    - D wins unless (req_c & counter>=STARVE_LIMIT);
//    - a lone requester always wins.
//    - The grant register updates at edge N when the request is seen at edge N. The bus shows the
//      master from cycle N+1, so there is 1 cycle of arbitration latency.
//  - Outputs in GNT_x: o_wb_{cyc,stb,we,sel,dat,adr,cti} = master x signals, combinational mux.
//    The other master's signals are ignored.
//  - Outputs in IDLE: o_wb_cyc=o_wb_stb=o_wb_we=0, and sel/dat/adr/cti=0.
//  - Ack routing: o_x_wb_ack = i_wb_ack & state==GNT_x & i_x_wb_cyc. It is never given to a non-owner.
//  - End of ownership is the first of:
//    (a) i_wb_ack with owner cti==111 or cti==000;
//    (b) owner deasserts i_x_wb_cyc (abort).
//    Ack while cyc is low is discarded.
//  - Back-to-back: at the end edge, re-arbitrate using the IDLE rule.
//    - If the other master requests, it is granted directly with no IDLE bubble.
//    - If only the same master requests, it is re-granted directly.
//    - Otherwise go to IDLE.
//  - Starvation counter (4 bit, saturating at 15):
//    - +1 on each D grant made while req_c=1;
//    - cleared on any C grant, and when req_c=0 at a D grant.
//  - Simultaneous: end of a D burst with req_c=1 and counter==STARVE_LIMIT-1 -> counter reaches
//    the limit, and the next arbitration grants C.
//  - A CTI of 001 or 011 from a master is treated as 000 for the end-of-ownership test.
//  - No combinational path from i_wb_ack to o_wb_cyc except via the registered state.
// STRUCTURE
//  - Shared package / zap_localparams.vh:
//    - CTI_CLASSIC=3'b000, CTI_BURST=3'b010, CTI_EOB=3'b111;
//    - ARB_IDLE/ARB_GNT_C/ARB_GNT_D 2-bit state encodings.
//  - One natural sub-module: zap_wb_arb_mux (pure 2:1 master-signal mux selected by the grant).
//  - The FSM and counter stay in the top.
// TESTING
//  1. Reset: hold i_reset_n=0 with both masters requesting -> o_wb_cyc=0, both acks=0, o_grant=00.
//     Release -> o_grant=10 (D) one cycle later.
//  2. Single C read: C cyc/stb, adr=0x100, cti=000; ack after 3 cycles -> o_wb_adr=0x100,
//     o_c_wb_ack pulses once, then IDLE, o_wb_cyc=0.
//  3. C burst of 4 (cti 010,010,010,111) with D requesting from cycle 1 -> no D ownership until the
//     4th ack; D is granted at the next edge with no idle cycle.
//  4. Starvation, STARVE_LIMIT=4: D issues 6 back-to-back singles while C requests continuously ->
//     grants D,D,D,D,C,D; counter clears on the C grant.
//  5. Abort: D drops cyc mid-burst after 2 of 4 acks, with a stray i_wb_ack next cycle ->
//     o_d_wb_ack=0 for the stray ack; C is granted if requesting.
//  6. Async reset mid-burst at beat 2 -> o_wb_cyc=0 in the same cycle, state=IDLE, counter=0.

Source files
------------

// File: rtl/zap_wb_burst_arbiter_pkg.sv
// Shared Wishbone arbiter types: cycle-type codes, FSM state encoding and the master payload.
package zap_wb_burst_arbiter_pkg;

    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_SW = 4;
    localparam int unsigned CTI_W = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [CTI_W-1:0] CTI_CONST   = 3'b001;
    localparam logic [CTI_W-1:0] CTI_BURST   = 3'b010;
    localparam logic [CTI_W-1:0] CTI_INCR    = 3'b011;
    localparam logic [CTI_W-1:0] CTI_EOB     = 3'b111;

    // One-hot grant encodings double as the {D,C} owner vector.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT_C = 2'b01,
        ARB_GNT_D = 2'b10
    } arb_state_t;

    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [WB_SW-1:0] sel;
        logic [WB_DW-1:0] dat;
        logic [WB_AW-1:0] adr;
        logic [CTI_W-1:0] cti;
    } wb_req_t;

    // True when an acked beat with this cycle type closes the owner's transaction.
    // Constant/incrementing-address codes are handled like classic single cycles.
    function automatic logic cti_last(input logic [CTI_W-1:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_CONST) ||
               (cti == CTI_INCR)    || (cti == CTI_EOB);
    endfunction

endpackage

// File: rtl/zap_wb_arb_mux.sv
// Steers the owning master's request onto the shared bus; idle drives all zeros.
module zap_wb_arb_mux
    import zap_wb_burst_arbiter_pkg::*;
(
    input  wb_req_t    c,
    input  wb_req_t    d,
    input  logic [1:0] grant,
    output wb_req_t    bus
);

    // Pure 2:1 select on the registered grant; the non-owner is ignored.
    always_comb begin
        bus = '0;
        case (grant)
            2'b01:   bus = c;
            2'b10:   bus = d;
            default: bus = '0;
        endcase
    end

endmodule

// File: rtl/zap_wb_burst_arbiter.sv
// Burst-aware Wishbone arbiter between the code cache (C) and data cache (D).
// Data has priority; code is guaranteed a grant after STARVE_LIMIT consecutive D grants.
module zap_wb_burst_arbiter
    import zap_wb_burst_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,

    input  logic             i_c_wb_cyc,
    input  logic             i_c_wb_stb,
    input  logic             i_c_wb_we,
    input  logic [WB_SW-1:0] i_c_wb_sel,
    input  logic [WB_DW-1:0] i_c_wb_dat,
    input  logic [WB_AW-1:0] i_c_wb_adr,
    input  logic [CTI_W-1:0] i_c_wb_cti,
    output logic             o_c_wb_ack,

    input  logic             i_d_wb_cyc,
    input  logic             i_d_wb_stb,
    input  logic             i_d_wb_we,
    input  logic [WB_SW-1:0] i_d_wb_sel,
    input  logic [WB_DW-1:0] i_d_wb_dat,
    input  logic [WB_AW-1:0] i_d_wb_adr,
    input  logic [CTI_W-1:0] i_d_wb_cti,
    output logic             o_d_wb_ack,

    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    output logic             o_wb_we,
    output logic [WB_SW-1:0] o_wb_sel,
    output logic [WB_DW-1:0] o_wb_dat,
    output logic [WB_AW-1:0] o_wb_adr,
    output logic [CTI_W-1:0] o_wb_cti,
    input  logic             i_wb_ack,

    output logic [1:0]       o_grant
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             req_c;
    logic             req_d;
    logic             starve;
    logic             owner_end;
    wb_req_t          c_req;
    wb_req_t          d_req;
    wb_req_t          bus;

    assign req_c  = i_c_wb_cyc & i_c_wb_stb;
    assign req_d  = i_d_wb_cyc & i_d_wb_stb;
    assign starve = req_c & (cnt_q >= LIMIT);

    assign c_req = '{cyc: i_c_wb_cyc, stb: i_c_wb_stb, we: i_c_wb_we, sel: i_c_wb_sel,
                     dat: i_c_wb_dat, adr: i_c_wb_adr, cti: i_c_wb_cti};
    assign d_req = '{cyc: i_d_wb_cyc, stb: i_d_wb_stb, we: i_d_wb_we, sel: i_d_wb_sel,
                     dat: i_d_wb_dat, adr: i_d_wb_adr, cti: i_d_wb_cti};

    // State and starvation counter; reset aborts any burst immediately.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Detect end of ownership, then re-arbitrate in the same edge (no idle bubble).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_end = 1'b0;

        case (state_q)
            ARB_GNT_C: owner_end = !i_c_wb_cyc || (i_wb_ack && cti_last(i_c_wb_cti));
            ARB_GNT_D: owner_end = !i_d_wb_cyc || (i_wb_ack && cti_last(i_d_wb_cti));
            default:   owner_end = 1'b1;
        endcase

        if (owner_end) begin
            if (req_d && !starve) begin
                state_d = ARB_GNT_D;
                if (!req_c) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (req_c) begin
                state_d = ARB_GNT_C;
                cnt_d   = '0;
            end else begin
                state_d = ARB_IDLE;
            end
        end
    end

    assign o_grant = {state_q == ARB_GNT_D, state_q == ARB_GNT_C};

    zap_wb_arb_mux u_mux (
        .c     (c_req),
        .d     (d_req),
        .grant (o_grant),
        .bus   (bus)
    );

    assign o_wb_cyc = bus.cyc;
    assign o_wb_stb = bus.stb;
    assign o_wb_we  = bus.we;
    assign o_wb_sel = bus.sel;
    assign o_wb_dat = bus.dat;
    assign o_wb_adr = bus.adr;
    assign o_wb_cti = bus.cti;

    // Acks only reach the current owner, and only while it still holds CYC.
    assign o_c_wb_ack = i_wb_ack & (state_q == ARB_GNT_C) & i_c_wb_cyc;
    assign o_d_wb_ack = i_wb_ack & (state_q == ARB_GNT_D) & i_d_wb_cyc;

    // Sanity: never two owners, never two acks.
    a_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n) $onehot0(o_grant));
    a_ack_exclusive: assert property (@(posedge i_clk) disable iff (!i_reset_n) !(o_c_wb_ack && o_d_wb_ack));

endmodule

// File: tb/tb_zap_wb_burst_arbiter.sv
// Directed bench for zap_wb_burst_arbiter with a per-cycle ownership model.
module tb_zap_wb_burst_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        c_cyc = 0, c_stb = 0, c_we = 0;
    logic [3:0]  c_sel = 4'hf;
    logic [31:0] c_dat = 32'hc0de_0001, c_adr = 32'h0;
    logic [2:0]  c_cti = 3'b000;
    logic        d_cyc = 0, d_stb = 0, d_we = 1;
    logic [3:0]  d_sel = 4'h3;
    logic [31:0] d_dat = 32'hda7a_0002, d_adr = 32'h0;
    logic [2:0]  d_cti = 3'b000;
    logic        wb_ack = 0;

    logic        o_c_ack, o_d_ack;
    logic        o_cyc, o_stb, o_we;
    logic [3:0]  o_sel;
    logic [31:0] o_dat, o_adr;
    logic [2:0]  o_cti;
    logic [1:0]  o_grant;

    int n_pass = 0;
    int n_total = 0;
    int c_ack_cnt = 0;

    // Model: owner 0 = idle, 1 = C, 2 = D; starve = consecutive D grants seen by a waiting C.
    int          m_owner = 0;
    int          m_starve = 0;
    logic [7:0]  glog[$];
    bit          m_rc, m_rd, m_free;

    logic [73:0] e_bus;
    logic [1:0]  e_grant;
    logic [1:0]  e_ack;

    always #5 clk = ~clk;

    zap_wb_burst_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_c_wb_cyc(c_cyc), .i_c_wb_stb(c_stb), .i_c_wb_we(c_we), .i_c_wb_sel(c_sel),
        .i_c_wb_dat(c_dat), .i_c_wb_adr(c_adr), .i_c_wb_cti(c_cti), .o_c_wb_ack(o_c_ack),
        .i_d_wb_cyc(d_cyc), .i_d_wb_stb(d_stb), .i_d_wb_we(d_we), .i_d_wb_sel(d_sel),
        .i_d_wb_dat(d_dat), .i_d_wb_adr(d_adr), .i_d_wb_cti(d_cti), .o_d_wb_ack(o_d_ack),
        .o_wb_cyc(o_cyc), .o_wb_stb(o_stb), .o_wb_we(o_we), .o_wb_sel(o_sel),
        .o_wb_dat(o_dat), .o_wb_adr(o_adr), .o_wb_cti(o_cti), .i_wb_ack(wb_ack),
        .o_grant(o_grant)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_last(input logic [2:0] cti);
        return (cti == 3'b000) || (cti == 3'b001) || (cti == 3'b011) || (cti == 3'b111);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Ownership model: a transaction frees the bus on final ack or abort; priority D unless C is starved.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner  = 0;
            m_starve = 0;
        end else begin
            m_rc = c_cyc && c_stb;
            m_rd = d_cyc && d_stb;
            if (m_owner == 1)      m_free = !c_cyc || (wb_ack && is_last(c_cti));
            else if (m_owner == 2) m_free = !d_cyc || (wb_ack && is_last(d_cti));
            else                   m_free = 1'b1;
            if (m_free) begin
                if (m_rd && !(m_rc && m_starve >= LIMIT)) begin
                    m_owner = 2;
                    glog.push_back("D");
                    m_starve = m_rc ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
                end else if (m_rc) begin
                    m_owner = 1;
                    glog.push_back("C");
                    m_starve = 0;
                end else begin
                    m_owner = 0;
                end
            end
        end
    end

    // Every-cycle comparison of grant, merged bus and ack routing against the model.
    always @(negedge clk) begin
        if (m_owner == 1)      e_bus = {c_cyc, c_stb, c_we, c_sel, c_dat, c_adr, c_cti};
        else if (m_owner == 2) e_bus = {d_cyc, d_stb, d_we, d_sel, d_dat, d_adr, d_cti};
        else                   e_bus = '0;
        e_grant = (m_owner == 2) ? 2'b10 : (m_owner == 1) ? 2'b01 : 2'b00;
        e_ack   = {wb_ack && m_owner == 1 && c_cyc, wb_ack && m_owner == 2 && d_cyc};
        check("model_grant", 80'(o_grant), 80'(e_grant));
        check("model_bus", 80'({o_cyc, o_stb, o_we, o_sel, o_dat, o_adr, o_cti}), 80'(e_bus));
        check("model_ack", 80'({o_c_ack, o_d_ack}), 80'(e_ack));
        if (o_c_ack) c_ack_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  t4_exp [6];
        logic [47:0] got6;
        logic [47:0] exp6;
        logic [23:0] got3;
        logic [23:0] exp3;
        t4_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        exp6 = "DDDDCD";
        exp3 = {8'd2, "C", "D"};

        // 1. Reset with both requesting, then D wins first.
        c_cyc = 1; c_stb = 1; c_adr = 32'h100;
        d_cyc = 1; d_stb = 1; d_adr = 32'h200;
        repeat (3) @(negedge clk);
        check("t1_rst_cyc", 80'(o_cyc), 80'(0));
        check("t1_rst_ack", 80'({o_c_ack, o_d_ack}), 80'(0));
        check("t1_rst_grant", 80'(o_grant), 80'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t1_first_grant", 80'(o_grant), 80'(2'b10));
        tick();
        c_cyc = 0; c_stb = 0; d_cyc = 0; d_stb = 0;
        tick();
        tick();

        // 2. Single classic C read, acked after three cycles.
        c_ack_cnt = 0;
        c_cyc = 1; c_stb = 1; c_adr = 32'h100; c_cti = 3'b000;
        tick();
        repeat (2) tick();
        wb_ack = 1;
        @(negedge clk);
        check("t2_adr", 80'(o_adr), 80'(32'h100));
        check("t2_ack", 80'(o_c_ack), 80'(1));
        tick();
        wb_ack = 0; c_cyc = 0; c_stb = 0;
        tick();
        @(negedge clk);
        check("t2_idle_grant", 80'(o_grant), 80'(0));
        check("t2_idle_cyc", 80'(o_cyc), 80'(0));
        check("t2_ack_count", 80'(c_ack_cnt), 80'(1));

        // 3. C burst of four while D waits; D takes over with no idle cycle.
        tick();
        glog.delete();
        c_cyc = 1; c_stb = 1; c_adr = 32'h300; c_cti = 3'b010;
        tick();
        d_cyc = 1; d_stb = 1; d_adr = 32'h400; d_cti = 3'b000;
        wb_ack = 1;
        for (int k = 0; k < 4; k++) begin
            c_cti = (k == 3) ? 3'b111 : 3'b010;
            @(negedge clk);
            check("t3_c_holds", 80'(o_grant), 80'(2'b01));
            tick();
        end
        wb_ack = 0; c_cyc = 0; c_stb = 0;
        @(negedge clk);
        check("t3_handover", 80'(o_grant), 80'(2'b10));
        got3 = {8'(glog.size()), (glog.size() > 0) ? glog[0] : 8'h2d,
                (glog.size() > 1) ? glog[1] : 8'h2d};
        check("t3_log", 80'(got3), 80'(exp3));
        tick();
        d_cyc = 0; d_stb = 0;
        tick();

        // 4. Starvation: D singles back-to-back, C waiting -> D,D,D,D,C,D.
        do_reset();
        glog.delete();
        c_cyc = 1; c_stb = 1; c_adr = 32'h500; c_cti = 3'b000;
        d_cyc = 1; d_stb = 1; d_adr = 32'h600; d_cti = 3'b000;
        wb_ack = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            check("t4_grant_seq", 80'(o_grant), 80'(t4_exp[i]));
        end
        got6 = '0;
        for (int i = 0; i < 6; i++)
            got6 = {got6[39:0], (i < glog.size()) ? glog[i] : 8'h2d};
        check("t4_model_log", 80'(got6), 80'(exp6));
        tick();
        c_cyc = 0; c_stb = 0; d_cyc = 0; d_stb = 0; wb_ack = 0;
        tick();

        // 5. D aborts a burst after two beats; the stray ack is dropped, C gets the bus.
        d_cyc = 1; d_stb = 1; d_adr = 32'h700; d_cti = 3'b010;
        c_cyc = 1; c_stb = 1; c_adr = 32'h800; c_cti = 3'b000;
        tick();
        wb_ack = 1;
        tick();
        tick();
        d_cyc = 0; d_stb = 0;
        @(negedge clk);
        check("t5_stray_d_ack", 80'(o_d_ack), 80'(0));
        check("t5_stray_c_ack", 80'(o_c_ack), 80'(0));
        tick();
        wb_ack = 0;
        @(negedge clk);
        check("t5_c_granted", 80'(o_grant), 80'(2'b01));
        tick();
        c_cyc = 0; c_stb = 0;
        tick();

        // 6. Asynchronous reset in the middle of a C burst.
        c_cyc = 1; c_stb = 1; c_adr = 32'h900; c_cti = 3'b010;
        tick();
        wb_ack = 1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_cyc", 80'(o_cyc), 80'(0));
        check("t6_async_grant", 80'(o_grant), 80'(0));
        check("t6_async_ack", 80'({o_c_ack, o_d_ack}), 80'(0));
        tick();
        c_cyc = 0; c_stb = 0; wb_ack = 0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
